// File: rtl/tile_config_slave.sv
// Tile-side configuration bus slave: decodes tile/feature address, captures writes into a
// local register file and answers readback with a fixed two-cycle latency.
module tile_config_slave #(
  parameter logic [15:0] TILE_ID    = 16'h0015,
  parameter logic [7:0]  FEATURE_ID = 8'h00,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in_n,
  input  logic [31:0]              config_addr_in,
  input  logic [31:0]              config_data_in,
  input  logic                     config_en_in,
  input  logic                     config_read_in,
  output logic [NUM_REGS*32-1:0]   config_reg_out,
  output logic [31:0]              read_data_out,
  output logic                     read_valid_out,
  output logic                     write_ack_out,
  output logic                     addr_err_out,
  output logic [15:0]              write_count_out
);

  logic        s1_valid;
  logic        s1_read;
  logic [31:0] s1_addr;
  logic [31:0] s1_data;

  logic [31:0] regs [NUM_REGS];

  logic [7:0]  s1_idx;
  logic        hit;
  logic        in_range;
  logic        commit_wr;
  logic [31:0] rd_word;

  assign s1_idx    = s1_addr[31:24];
  assign hit       = s1_valid && (s1_addr[15:0] == TILE_ID) && (s1_addr[23:16] == FEATURE_ID);
  assign in_range  = ({1'b0, s1_idx} < 9'(NUM_REGS));
  assign commit_wr = hit && !s1_read && in_range;

  // Stage 1: bus capture
  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      s1_valid <= 1'b0;
      s1_read  <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= config_en_in;
      if (config_en_in) begin
        s1_addr <= config_addr_in;
        s1_data <= config_data_in;
        s1_read <= config_read_in;
      end
    end
  end

  // Readback mux; reads in stage 2 see writes committed one edge earlier
  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (s1_idx == 8'(k)) rd_word = regs[k];
    end
  end

  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (commit_wr) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (s1_idx == 8'(k)) regs[k] <= s1_data;
      end
    end
  end

  // Stage 2: response outputs
  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      read_data_out   <= '0;
      read_valid_out  <= 1'b0;
      write_ack_out   <= 1'b0;
      addr_err_out    <= 1'b0;
      write_count_out <= '0;
    end else begin
      write_ack_out  <= commit_wr;
      read_valid_out <= hit && s1_read;
      if (hit && s1_read) begin
        read_data_out <= in_range ? rd_word : '0;
      end
      if (hit && !in_range) begin
        addr_err_out <= 1'b1;
      end
      if (commit_wr && (write_count_out != '1)) begin
        write_count_out <= write_count_out + 16'd1;
      end
    end
  end

  always_comb begin
    config_reg_out = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      config_reg_out[32*k +: 32] = regs[k];
    end
  end

endmodule
